// File: rtl/bomber_pkg.sv
// Shared types for the bomb controller / map writer pair: tile codes,
// controller state codes, flame directions, writer FSM states and the
// reset map pattern.
package bomber_pkg;

  localparam int MAP_W_DEF = 15;
  localparam int MAP_H_DEF = 13;

  typedef enum logic [2:0] {
    T_EMPTY       = 3'd0,
    T_WALL        = 3'd1,
    T_BRICK       = 3'd2,
    T_BOMB        = 3'd3,
    T_FLAME       = 3'd4,
    T_FLAME_BRICK = 3'd5
  } tile_t;

  typedef enum logic [2:0] {
    BOB_BOMB    = 3'd0,
    BOB_FLAME   = 3'd1,
    BOB_EMPTY   = 3'd2,
    BOB_RESTORE = 3'd3
  } bob_state_t;

  typedef enum logic [1:0] {
    DIR_PX = 2'd0,
    DIR_NX = 2'd1,
    DIR_PY = 2'd2,
    DIR_NY = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLACE,
    S_FL_CTR,
    S_FL_ARM,
    S_CL_CTR,
    S_CL_ARM
  } fsm_t;

  // Border and even/even pillars are walls; bricks on every third
  // anti-diagonal except the three cells around the player spawn.
  function automatic tile_t init_tile(input int x, input int y, input int w, input int h);
    if (x == 0 || x == w - 1 || y == 0 || y == h - 1 || (x % 2 == 0 && y % 2 == 0))
      return T_WALL;
    if ((x + y) % 3 == 0 && !((x == 1 && y == 1) || (x == 1 && y == 2) || (x == 2 && y == 1)))
      return T_BRICK;
    return T_EMPTY;
  endfunction

  // Lowest-numbered direction whose bit is set in m (DIR_NY when none).
  function automatic dir_t low_dir(input logic [3:0] m);
    if (m[0]) return DIR_PX;
    if (m[1]) return DIR_NX;
    if (m[2]) return DIR_PY;
    return DIR_NY;
  endfunction

endpackage

// File: rtl/blast_map_writer_tile_map_regs.sv
// Tile map storage: one register per tile, reset to the arena layout.
// One write port, two combinational readers and a player probe; any
// out-of-range read returns WALL so callers need no extra bounds logic.
module tile_map_regs
  import bomber_pkg::*;
#(
  parameter int MAP_W = MAP_W_DEF,
  parameter int MAP_H = MAP_H_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [3:0] wx,
  input  logic [3:0] wy,
  input  logic [2:0] wdata,
  input  logic [3:0] ax,
  input  logic [3:0] ay,
  output logic [2:0] a_tile,
  input  logic [3:0] bx,
  input  logic [3:0] by,
  output logic [2:0] b_tile,
  input  logic [3:0] px,
  input  logic [3:0] py,
  output logic [2:0] p_tile
);

  localparam logic [3:0] X_LIM     = 4'(MAP_W);
  localparam logic [3:0] Y_LIM     = 4'(MAP_H);
  localparam logic [2:0] WALL_CODE = T_WALL;

  logic [2:0] cells [MAP_H][MAP_W];

  // Reset rebuilds the whole arena; otherwise apply the single write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int yy = 0; yy < MAP_H; yy++)
        for (int xx = 0; xx < MAP_W; xx++)
          cells[4'(yy)][4'(xx)] <= init_tile(xx, yy, MAP_W, MAP_H);
    end else if (we && wx < X_LIM && wy < Y_LIM) begin
      cells[wy][wx] <= wdata;
    end
  end

  assign a_tile = (ax < X_LIM && ay < Y_LIM) ? cells[ay][ax] : WALL_CODE;
  assign b_tile = (bx < X_LIM && by < Y_LIM) ? cells[by][bx] : WALL_CODE;
  assign p_tile = (px < X_LIM && py < Y_LIM) ? cells[py][px] : WALL_CODE;

endmodule

// File: rtl/blast_map_writer.sv
// Map writer at the consumer end of the bomb controller stream. Detects
// controller state changes, queues one event while busy, and walks the
// map to place bombs, spread flame arms (burning bricks) and restore the
// blast cells afterwards. Also flags a player standing in flame.
module blast_map_writer
  import bomber_pkg::*;
#(
  parameter int MAP_W       = MAP_W_DEF,
  parameter int MAP_H       = MAP_H_DEF,
  parameter int FLAME_RANGE = 2
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [2:0] bomb_state,
  input  logic [3:0] bomb_x,
  input  logic [3:0] bomb_y,
  input  logic [3:0] px,
  input  logic [3:0] py,
  input  logic [3:0] rd_x,
  input  logic [3:0] rd_y,
  output logic [2:0] rd_tile,
  output logic       busy,
  output logic       player_hit
);

  localparam logic [3:0] X_LIM = 4'(MAP_W);
  localparam logic [3:0] Y_LIM = 4'(MAP_H);
  localparam logic [2:0] RANGE = 3'(FLAME_RANGE);

  fsm_t       state, state_nx;
  dir_t       dir, dir_nx;
  logic [2:0] step, step_nx;
  logic [2:0] arm_len [4];

  logic [2:0] prev_state;
  logic       new_evt;
  logic [3:0] evt_x, evt_y;
  logic       pend_vld;
  logic [2:0] pend_state;
  logic [3:0] pend_x, pend_y;
  logic [2:0] src_state;

  logic [3:0] cx, cy;
  logic       in_range;
  logic [2:0] probe, p_tile;
  logic       blocked, brick, arm_end;
  logic [3:0] nz_mask, above_mask;
  logic       has_nz_all, has_nz_after;
  dir_t       nz_all, nz_after;

  logic       we;
  logic [2:0] wdata;

  assign new_evt = (bomb_state != prev_state);

  tile_map_regs #(
    .MAP_W (MAP_W),
    .MAP_H (MAP_H)
  ) u_map (
    .clk    (frame_clk),
    .rst    (Reset),
    .we     (we),
    .wx     (cx),
    .wy     (cy),
    .wdata  (wdata),
    .ax     (cx),
    .ay     (cy),
    .a_tile (probe),
    .bx     (rd_x),
    .by     (rd_y),
    .b_tile (rd_tile),
    .px     (px),
    .py     (py),
    .p_tile (p_tile)
  );

  // Cell under the FSM: the centre, or centre + dir*step on arm walks (4-bit wrap).
  always_comb begin
    cx = evt_x;
    cy = evt_y;
    if (state == S_FL_ARM || state == S_CL_ARM) begin
      case (dir)
        DIR_PX:  cx = evt_x + {1'b0, step};
        DIR_NX:  cx = evt_x - {1'b0, step};
        DIR_PY:  cy = evt_y + {1'b0, step};
        default: cy = evt_y - {1'b0, step};
      endcase
    end
    in_range = (cx < X_LIM) && (cy < Y_LIM);
  end

  // Arm-walk decisions: flame stoppers and which restore arms remain.
  always_comb begin
    blocked = !in_range || probe == T_WALL || probe == T_BOMB;
    brick   = in_range && probe == T_BRICK;
    arm_end = blocked || brick || step == RANGE;
    nz_mask[0] = (arm_len[0] != 3'd0);
    nz_mask[1] = (arm_len[1] != 3'd0);
    nz_mask[2] = (arm_len[2] != 3'd0);
    nz_mask[3] = (arm_len[3] != 3'd0);
    case (dir)
      DIR_PX:  above_mask = 4'b1110;
      DIR_NX:  above_mask = 4'b1100;
      DIR_PY:  above_mask = 4'b1000;
      default: above_mask = 4'b0000;
    endcase
    has_nz_all   = |nz_mask;
    nz_all       = low_dir(nz_mask);
    has_nz_after = |(nz_mask & above_mask);
    nz_after     = low_dir(nz_mask & above_mask);
  end

  // FSM state register.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state plus arm direction/step; IDLE prefers the queued event.
  always_comb begin
    state_nx  = state;
    dir_nx    = dir;
    step_nx   = step;
    src_state = pend_vld ? pend_state : (new_evt ? bomb_state : BOB_EMPTY);
    case (state)
      S_IDLE: begin
        case (src_state)
          BOB_BOMB:    state_nx = S_PLACE;
          BOB_FLAME:   state_nx = S_FL_CTR;
          BOB_RESTORE: state_nx = S_CL_CTR;
          default:     state_nx = S_IDLE;
        endcase
      end
      S_PLACE: state_nx = S_IDLE;
      S_FL_CTR: begin
        state_nx = S_FL_ARM;
        dir_nx   = DIR_PX;
        step_nx  = 3'd1;
      end
      S_FL_ARM: begin
        if (arm_end) begin
          if (dir == DIR_NY) begin
            state_nx = S_IDLE;
          end else begin
            dir_nx  = dir_t'(dir + 2'd1);
            step_nx = 3'd1;
          end
        end else begin
          step_nx = step + 3'd1;
        end
      end
      S_CL_CTR: begin
        if (has_nz_all) begin
          state_nx = S_CL_ARM;
          dir_nx   = nz_all;
          step_nx  = 3'd1;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_CL_ARM: begin
        if (step == arm_len[dir]) begin
          if (has_nz_after) begin
            dir_nx  = nz_after;
            step_nx = 3'd1;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          step_nx = step + 3'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Map write strobe and data for the current FSM state.
  always_comb begin
    busy  = (state != S_IDLE);
    we    = 1'b0;
    wdata = T_EMPTY;
    case (state)
      S_PLACE: begin
        we    = (probe == T_EMPTY);
        wdata = T_BOMB;
      end
      S_FL_CTR: begin
        we    = 1'b1;
        wdata = T_FLAME;
      end
      S_FL_ARM: begin
        we    = !blocked;
        wdata = brick ? T_FLAME_BRICK : T_FLAME;
      end
      S_CL_CTR, S_CL_ARM: begin
        we    = 1'b1;
        wdata = T_EMPTY;
      end
      default: ;
    endcase
  end

  // Control state: edge history, pending flag, arm bookkeeping, hit flag.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      prev_state <= BOB_EMPTY;
      pend_vld   <= 1'b0;
      dir        <= DIR_PX;
      step       <= 3'd1;
      arm_len[0] <= 3'd0;
      arm_len[1] <= 3'd0;
      arm_len[2] <= 3'd0;
      arm_len[3] <= 3'd0;
      player_hit <= 1'b0;
    end else begin
      prev_state <= bomb_state;
      dir        <= dir_nx;
      step       <= step_nx;
      if (state == S_IDLE) pend_vld <= pend_vld & new_evt;
      else if (new_evt)    pend_vld <= 1'b1;
      if (state == S_FL_ARM && arm_end)
        arm_len[dir] <= blocked ? step - 3'd1 : step;
      player_hit <= (p_tile == T_FLAME) || (p_tile == T_FLAME_BRICK);
    end
  end

  // Event payloads: IDLE consumes the pending slot first, busy refills it.
  always_ff @(posedge frame_clk) begin
    if (state == S_IDLE) begin
      if (pend_vld) begin
        evt_x <= pend_x;
        evt_y <= pend_y;
        if (new_evt) begin
          pend_state <= bomb_state;
          pend_x     <= bomb_x;
          pend_y     <= bomb_y;
        end
      end else if (new_evt) begin
        evt_x <= bomb_x;
        evt_y <= bomb_y;
      end
    end else if (new_evt) begin
      pend_state <= bomb_state;
      pend_x     <= bomb_x;
      pend_y     <= bomb_y;
    end
  end

endmodule

// File: tb/tb_blast_map_writer.sv
// Directed bench for blast_map_writer: reset map, bomb placement, flame
// walk with brick burn, player hit, restore, queued event and mid-walk reset.
module tb_blast_map_writer;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [2:0] bomb_state;
  logic [3:0] bomb_x, bomb_y, px, py, rd_x, rd_y;
  logic [2:0] rd_tile;
  logic       busy, player_hit;

  int n_assert = 0;
  int n_fail   = 0;
  int nb       = 0;

  localparam int EMPTY = 0, WALL = 1, BRICK = 2, BOMB = 3, FLAME = 4, FLAME_BRICK = 5;

  blast_map_writer dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .bomb_state (bomb_state),
    .bomb_x     (bomb_x),
    .bomb_y     (bomb_y),
    .px         (px),
    .py         (py),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_tile    (rd_tile),
    .busy       (busy),
    .player_hit (player_hit)
  );

  always #50 frame_clk = ~frame_clk;

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tile_is(input string tag, input int x, input int y, input int exp);
    rd_x = 4'(x);
    rd_y = 4'(y);
    #1;
    chk(tag, 32'(rd_tile), 32'(exp));
  endtask

  task automatic step_clk;
    @(posedge frame_clk);
    #2;
  endtask

  task automatic adv;
    step_clk;
    if (busy === 1'b1) nb++;
  endtask

  task automatic drain;
    int g;
    g = 0;
    while (busy === 1'b1 && g < 40) begin
      adv;
      g++;
    end
  endtask

  task automatic drive(input int s, input int x, input int y);
    bomb_state = 3'(s);
    bomb_x     = 4'(x);
    bomb_y     = 4'(y);
  endtask

  initial begin
    Reset = 1'b1;
    drive(2, 0, 0);
    px = 4'd1; py = 4'd1;
    rd_x = 4'd0; rd_y = 4'd0;
    #120;
    @(negedge frame_clk);
    Reset = 1'b0;

    // Test 1: reset map and outputs
    tile_is("rst_0_0", 0, 0, WALL);
    tile_is("rst_2_2", 2, 2, WALL);
    tile_is("rst_3_3", 3, 3, BRICK);
    tile_is("rst_1_2", 1, 2, EMPTY);
    tile_is("rst_5_1", 5, 1, BRICK);
    tile_is("oob_x15", 15, 1, WALL);
    tile_is("oob_y13", 3, 13, WALL);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_hit", 32'(player_hit), 0);

    // Test 2: place bomb at (4,1), one busy cycle
    step_clk;
    drive(0, 4, 1);
    step_clk;
    chk("place_busy_n", 32'(busy), 1);
    tile_is("place_pre", 4, 1, EMPTY);
    step_clk;
    chk("place_busy_n1", 32'(busy), 0);
    tile_is("place_bomb", 4, 1, BOMB);

    // Test 3: flame at (4,1) with player on (3,1)
    px = 4'd3; py = 4'd1;
    drive(1, 4, 1);
    nb = 0;
    adv; adv; adv; adv;
    tile_is("fl_3_1_mid", 3, 1, FLAME);
    chk("hit_before", 32'(player_hit), 0);
    adv;
    chk("hit_after", 32'(player_hit), 1);
    drain;
    chk("fl_busy_cnt", 32'(nb), 6);
    tile_is("fl_4_1", 4, 1, FLAME);
    tile_is("fl_5_1", 5, 1, FLAME_BRICK);
    tile_is("fl_3_1", 3, 1, FLAME);
    tile_is("fl_2_1", 2, 1, FLAME);
    tile_is("fl_4_2", 4, 2, WALL);
    tile_is("fl_4_0", 4, 0, WALL);
    tile_is("fl_6_1", 6, 1, EMPTY);
    chk("hit_hold", 32'(player_hit), 1);

    // Test 4: restore clears the recorded arms
    drive(3, 4, 1);
    nb = 0;
    adv;
    drain;
    chk("cl_busy_cnt", 32'(nb), 4);
    tile_is("cl_4_1", 4, 1, EMPTY);
    tile_is("cl_3_1", 3, 1, EMPTY);
    tile_is("cl_2_1", 2, 1, EMPTY);
    tile_is("cl_5_1", 5, 1, EMPTY);
    tile_is("cl_4_2", 4, 2, WALL);
    chk("hit_clear", 32'(player_hit), 0);

    // Test 5: restore arrives while the flame walk is still busy
    drive(0, 4, 1);
    adv;
    drain;
    tile_is("q_bomb", 4, 1, BOMB);
    drive(1, 4, 1);
    nb = 0;
    adv;
    drive(3, 4, 1);
    drain;
    chk("q_fl_cnt", 32'(nb), 7);
    tile_is("q_6_1_fl", 6, 1, FLAME);
    nb = 0;
    adv;
    drain;
    chk("q_cl_cnt", 32'(nb), 5);
    tile_is("q_4_1", 4, 1, EMPTY);
    tile_is("q_5_1", 5, 1, EMPTY);
    tile_is("q_6_1", 6, 1, EMPTY);
    tile_is("q_3_1", 3, 1, EMPTY);
    tile_is("q_2_1", 2, 1, EMPTY);
    tile_is("q_3_3", 3, 3, BRICK);
    tile_is("q_4_2", 4, 2, WALL);

    // Test 6: reset during the third flame-walk cycle
    drive(1, 4, 1);
    step_clk;
    step_clk;
    step_clk;
    tile_is("r_pre_5_1", 5, 1, FLAME);
    Reset = 1'b1;
    drive(2, 4, 1);
    #1;
    chk("r_busy", 32'(busy), 0);
    tile_is("r_5_1", 5, 1, BRICK);
    tile_is("r_4_1", 4, 1, EMPTY);
    step_clk;
    Reset = 1'b0;
    drive(0, 4, 1);
    step_clk;
    chk("r_place_busy", 32'(busy), 1);
    step_clk;
    chk("r_place_done", 32'(busy), 0);
    tile_is("r_bomb", 4, 1, BOMB);

    // State 2 is no action; a bomb on a brick leaves the brick
    drive(2, 5, 1);
    step_clk;
    chk("empty_noact", 32'(busy), 0);
    drive(0, 5, 1);
    adv;
    drain;
    tile_is("bomb_on_brick", 5, 1, BRICK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
